// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared constants for the two-port adder sequencer.
// State encoding, port ids, word width, and the carry-out helper used on
// both adder passes.
package adder_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Carry out of the top bit of a pass, rebuilt from the adder-input MSBs
  // and the sum MSB (cla32 only returns the sum).
  function automatic logic carry_out(input logic a, input logic b, input logic s);
    return (a & b) | ((a ^ b) & ~s);
  endfunction

endpackage

// File: rtl/adder_arbiter_grant.sv
// adder_arbiter_grant: two-input grant with a last-granted flop.
// RR=1 alternates on contention; RR=0 always favours port 0.
// The flop resets to "last = port 1" so the first contended grant is port 0.
module adder_arbiter_grant
  import adder_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic clrn,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  logic last;
  logic pick1;

  // Remember which port won the most recent accepted request
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) last <= PORT1;
    else if (update) last <= gnt1;
  end

  // One-hot grant: a lone requester wins, contention resolved by RR mode
  always_comb begin
    pick1 = RR ? ~last : 1'b0;
    gnt1  = req1 & (~req0 | pick1);
    gnt0  = req0 & ~gnt1;
  end

endmodule

// File: rtl/cla32.sv
// cla32: 32-bit carry-lookahead adder, sum only.
// Eight 4-bit lookahead groups; the group carry chains between groups.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic        cg;

  assign g = a & b;
  assign p = a ^ b;

  // Per-bit carries from 4-bit lookahead groups with a rippled group carry
  always_comb begin
    c  = '0;
    gg = '0;
    pp = '0;
    cg = ci;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      c[4*k]     = cg;
      c[4*k + 1] = gg[0] | (pp[0] & cg);
      c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg);
      c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cg);
      cg = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cg);
    end
  end

  assign s = p ^ c;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one cla32 between an integer unit (port 0) and the
// FPU mantissa path (port 1). 32-bit ops take one adder pass, 64-bit ops
// take two (low word, then high word with the low-pass carry).
// Optional macro ADDARB_SUB_EN adds rN_sub ports for subtraction
// (b inverted, low-pass carry-in 1, rsp_co=1 means no borrow).
//
// Handshake: a request moves when rN_valid && rN_ready on a rising edge;
// only the granted port sees ready, and only in IDLE after reset has been
// released for one edge. rsp_valid rises on the edge that enters RESP
// (second cycle after accept for 32-bit, third for 64-bit) and holds
// rsp_id/rsp_s/rsp_co stable until rsp_ready is sampled high.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [63:0] r0_a,
  input  logic [63:0] r0_b,
  input  logic        r0_dw,
`ifdef ADDARB_SUB_EN
  input  logic        r0_sub,
  input  logic        r1_sub,
`endif
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [63:0] r1_a,
  input  logic [63:0] r1_b,
  input  logic        r1_dw,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_s,
  output logic        rsp_co,
  output logic [1:0]  dbg_state
);

  state_t state;
  state_t state_nxt;

  logic        rst_done;
  logic        gnt0;
  logic        gnt1;
  logic        accept;

  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_dw;
  logic        op_id;
  logic        op_sub;

  logic [WORD_W-1:0] s_lo;
  logic              c31;

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b_raw;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_s;
  logic              add_ci;
  logic              add_co;

  adder_arbiter_grant #(.RR(RR)) u_grant (
    .clk    (clk),
    .clrn   (clrn),
    .req0   (r0_valid),
    .req1   (r1_valid),
    .update (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  cla32 u_cla32 (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s)
  );

  assign add_co    = carry_out(add_a[WORD_W-1], add_b[WORD_W-1], add_s[WORD_W-1]);
  assign accept    = (r0_valid & r0_ready) | (r1_valid & r1_ready);
  assign dbg_state = state;

  // Readies stay low until the first edge after reset release
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) rst_done <= 1'b0;
    else rst_done <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // Next-state: IDLE -> LO -> (HI if 64-bit) -> RESP -> IDLE on rsp_ready
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LO;
      ST_LO:   state_nxt = op_dw ? ST_HI : ST_RESP;
      ST_HI:   state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs/adder steering: grant-gated readies, word select, sub inversion
  always_comb begin
    r0_ready  = rst_done & (state == ST_IDLE) & gnt0;
    r1_ready  = rst_done & (state == ST_IDLE) & gnt1;
    add_a     = (state == ST_HI) ? op_a[63:32] : op_a[31:0];
    add_b_raw = (state == ST_HI) ? op_b[63:32] : op_b[31:0];
    add_b     = op_sub ? ~add_b_raw : add_b_raw;
    add_ci    = (state == ST_HI) ? c31 : op_sub;
  end

`ifdef ADDARB_SUB_EN
  // Latch the subtract flag of the accepted request
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) op_sub <= 1'b0;
    else if (state == ST_IDLE && accept) op_sub <= r1_ready ? r1_sub : r0_sub;
  end
`else
  assign op_sub = 1'b0;
`endif

  // Operand capture, pass results and the registered response
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      op_a      <= '0;
      op_b      <= '0;
      op_dw     <= 1'b0;
      op_id     <= PORT0;
      s_lo      <= '0;
      c31       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= PORT0;
      rsp_s     <= '0;
      rsp_co    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= r1_ready ? r1_a : r0_a;
            op_b  <= r1_ready ? r1_b : r0_b;
            op_dw <= r1_ready ? r1_dw : r0_dw;
            op_id <= r1_ready ? PORT1 : PORT0;
          end
        end
        ST_LO: begin
          s_lo <= add_s;
          c31  <= add_co;
          if (!op_dw) begin
            rsp_s     <= {32'b0, add_s};
            rsp_co    <= add_co;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
          end
        end
        ST_HI: begin
          rsp_s     <= {add_s, s_lo};
          rsp_co    <= add_co;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks for the two-port adder sequencer.
// Covers reset, 32/64-bit latency and results, backpressure, reset during
// the high pass, round-robin contention and (with ADDARB_SUB_EN) subtract.
module tb_adder_arbiter;

  localparam bit RR_P = 1'b1;

  logic        clk = 1'b0;
  logic        clrn;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [63:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_dw, r1_dw;
`ifdef ADDARB_SUB_EN
  logic        r0_sub, r1_sub;
`endif
  logic        rsp_valid, rsp_ready, rsp_id, rsp_co;
  logic [63:0] rsp_s;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.RR(RR_P)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_dw     (r0_dw),
`ifdef ADDARB_SUB_EN
    .r0_sub    (r0_sub),
    .r1_sub    (r1_sub),
`endif
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_dw     (r1_dw),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_co    (rsp_co),
    .dbg_state (dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic dw);
    if (port == 0) begin
      r0_valid = v; r0_a = a; r0_b = b; r0_dw = dw;
    end else begin
      r1_valid = v; r1_a = a; r1_b = b; r1_dw = dw;
    end
  endtask

  task automatic wait_ready(input int port);
    for (int n = 0; n < 20; n++) begin
      if ((port == 0 && r0_ready) || (port == 1 && r1_ready)) break;
      tick;
    end
    chk("ready_seen", (port == 0) ? r0_ready : r1_ready, 1);
  endtask

  task automatic wait_rsp;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) break;
      tick;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  // Issue one op, check the exact latency and the response, then retire it
  task automatic run_op(input int port, input logic [63:0] a, input logic [63:0] b,
                        input logic dw, input logic [63:0] exp_s, input logic exp_co,
                        input int lat);
    rsp_ready = 1'b1;
    set_req(port, 1'b1, a, b, dw);
    wait_ready(port);
    tick;
    set_req(port, 1'b0, '0, '0, 1'b0);
    for (int i = 1; i < lat; i++) begin
      chk("latency_low", rsp_valid, 0);
      tick;
    end
    chk("latency_high", rsp_valid, 1);
    chk("op_sum", rsp_s, exp_s);
    chk("op_co", rsp_co, exp_co);
    chk("op_id", rsp_id, port[0]);
    tick;
    chk("retire", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_g;
    clrn = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
`ifdef ADDARB_SUB_EN
    r0_sub = 1'b0;
    r1_sub = 1'b0;
`endif
    repeat (3) tick;

    // Reset values
    chk("rst_valid", rsp_valid, 0);
    chk("rst_s", rsp_s, 64'h0);
    chk("rst_co", rsp_co, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_state", dbg_state, 0);

    // Release reset mid-cycle: ready must wait for the first edge
    set_req(0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    rsp_ready = 1'b0;
    clrn = 1'b1;
    #1;
    chk("ready_before_first_edge", r0_ready, 0);
    tick;
    chk("ready_after_first_edge", r0_ready, 1);
    chk("r1_not_ready", r1_ready, 0);

    // 32-bit port 0: FFFF_FFFF + 1, valid in 2nd cycle after accept
    tick;
    set_req(0, 1'b0, '0, '0, 1'b0);
    chk("p0_cycle1_valid", rsp_valid, 0);
    chk("p0_cycle1_state", dbg_state, 1);
    tick;
    chk("p0_valid", rsp_valid, 1);
    chk("p0_sum", rsp_s, 64'h0);
    chk("p0_co", rsp_co, 1);
    chk("p0_id", rsp_id, 0);

    // Backpressure for 5 cycles with port 1 waiting
    set_req(1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_s, 64'h0);
      chk("bp_co", rsp_co, 1);
      chk("bp_r0_ready", r0_ready, 0);
      chk("bp_r1_ready", r1_ready, 0);
    end
    rsp_ready = 1'b1;
    tick;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_state", dbg_state, 0);
    chk("bp_release_r1_ready", r1_ready, 1);

    // 64-bit port 1: 0x0000_0000_FFFF_FFFF + 1, valid in 3rd cycle
    tick;
    set_req(1, 1'b0, '0, '0, 1'b0);
    chk("p1_cycle1_valid", rsp_valid, 0);
    tick;
    chk("p1_cycle2_valid", rsp_valid, 0);
    chk("p1_cycle2_state", dbg_state, 2);
    tick;
    chk("p1_valid", rsp_valid, 1);
    chk("p1_sum", rsp_s, 64'h0000_0001_0000_0000);
    chk("p1_co", rsp_co, 0);
    chk("p1_id", rsp_id, 1);
    tick;
    chk("p1_retire", rsp_valid, 0);

    // More directed vectors
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h0, 1'b1, 3);
    run_op(1, 64'hDEAD_BEEF_0000_0010, 64'h1234_0000_FFFF_FFF0, 1'b0, 64'h0, 1'b1, 2);
    run_op(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1,
           64'h2345_6789_ABCD_F001, 1'b0, 3);
    run_op(1, 64'hAAAA_AAAA_8000_0000, 64'h5555_5555_8000_0000, 1'b1,
           64'h0000_0000_0000_0000, 1'b1, 3);

    // Reset during the high pass of a 64-bit op
    set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    wait_ready(1);
    tick;
    set_req(1, 1'b0, '0, '0, 1'b0);
    tick;
    chk("mid_hi_state", dbg_state, 2);
    clrn = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_r0_ready", r0_ready, 0);
    chk("mid_rst_r1_ready", r1_ready, 0);
    chk("mid_rst_state", dbg_state, 0);
    tick;
    tick;

    // Contention: both ports valid continuously, pointer restarts at port 0
    set_req(0, 1'b1, 64'h10, 64'h20, 1'b0);
    set_req(1, 1'b1, 64'h7FFF_FFFF, 64'h1, 1'b0);
    clrn = 1'b1;
    #1;
    chk("rel_r0_ready", r0_ready, 0);
    chk("rel_r1_ready", r1_ready, 0);
    tick;
    chk("no_stale_rsp", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 20; n++) begin
        if (r0_ready || r1_ready) break;
        tick;
      end
      exp_g = RR_P && (i % 2 == 1);
      chk("one_ready", {r1_ready, r0_ready}, exp_g ? 2'b10 : 2'b01);
      tick;
      wait_rsp;
      chk("cont_id", rsp_id, exp_g);
      chk("cont_sum", rsp_s, exp_g ? 64'h8000_0000 : 64'h30);
      chk("cont_co", rsp_co, 0);
      tick;
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);

`ifdef ADDARB_SUB_EN
    // Subtract: 0 - 1 (64-bit) borrows; 5 - 3 (32-bit) does not
    r1_sub = 1'b1;
    run_op(1, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
    r1_sub = 1'b0;
    r0_sub = 1'b1;
    run_op(0, 64'h5, 64'h3, 1'b0, 64'h2, 1'b1, 2);
    r0_sub = 1'b0;
`endif

    repeat (2) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Sequences and shares one 32-bit carry-lookahead adder (existing cla32, 32-bit a/b, carry-in, sum only) between two requesters: integer multi-cycle unit (port 0) and FPU mantissa path (port 1).
- Supports 32-bit ops in one adder pass and 64-bit ops in two passes (low word, then high word with propagated carry).
- Sits beside the EX stage; one operation outstanding at a time; registered response with valid/ready.

Parameters:
- RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- r0_valid  in  1  port 0 request valid
- r0_ready  out  1  port 0 request accepted when valid&ready
- r0_a, r0_b  in  64  port 0 operands (upper 32 ignored when r0_dw=0)
- r0_dw  in  1  port 0 64-bit op
- r0_sub  in  1  port 0 subtract (ADDARB_SUB_EN only)
- r1_valid, r1_ready, r1_a, r1_b, r1_dw, r1_sub  same as port 0 for port 1
- rsp_valid  out  1  result valid, held until rsp_ready
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  port that issued the op
- rsp_s  out  64  sum; [63:32]=0 for 32-bit ops
- rsp_co  out  1  carry out of bit 31 (32-bit op) or bit 63 (64-bit op)

Behaviour:
- Reset (clrn=0, async): state IDLE, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_co=0, rr pointer favours port 0, rst_done=0; r0_ready=r1_ready=0 while clrn=0 and until the first rising edge after release (rst_done set).
- States: IDLE, LO, HI, RESP.
- IDLE: rN_ready=1 only for the granted port. Grant: one valid port wins; both valid -> RR=1: port other than last granted; RR=0: port 0. Never more than one ready high. On accept, latch a, b, dw, sub, id; update last-granted; go LO.
- LO: adder a=opA[31:0], b=opB[31:0] (inverted if sub), ci=sub. Register s_lo; carry c31=(a31&b31)|((a31^b31)&~s31) using the adder-input bits. dw=1 -> HI; else rsp_s={32'b0,s_lo}, rsp_co=c31 -> RESP.
- HI: adder on upper words, ci=c31; register s_hi; carry c63 by the same formula; rsp_s={s_hi,s_lo}, rsp_co=c63 -> RESP.
- RESP: rsp_valid=1; outputs stable until rsp_ready=1 sampled high; then rsp_valid=0 -> IDLE. No new request accepted in RESP (ready=0).
- Latency accept-edge to rsp_valid: 2 cycles (32-bit), 3 cycles (64-bit). Throughput max one op per 3 (or 4) cycles.
- Request inputs ignored outside IDLE; a requester holding valid keeps it until accepted.
- Arithmetic modulo 2^32 / 2^64; no overflow flag; wrap-around reported only through rsp_co.
- Reset mid-operation: op discarded, no response, return to IDLE, pointer reset.
- Single shared adder instance; the block instantiates it exactly once.

Optional Feature:
- ADDARB_SUB_EN defined: rN_sub ports present; sub=1 inverts b into the adder and sets ci=1 on low pass; rsp_co=1 means no borrow.
- Not defined: rN_sub ports absent; b never inverted, low-pass ci=0.

Decomposition:
- Package adder_arbiter_pkg: state encoding constants (IDLE=2'd0, LO=2'd1, HI=2'd2, RESP=2'd3), port-id constants, word width 32.
- Natural sub-module: adder_arbiter_grant (two-input round-robin/fixed grant with last-grant flop); adder pass itself is the existing cla32.

Test Plan:
- Reset: clrn low mid-HI of 64-bit op -> rsp_valid=0 immediately, readies 0, first edge after release ready again, no stale response.
- 32-bit port 0: a=0xFFFF_FFFF, b=1 -> rsp_s=0x0000_0000_0000_0000, rsp_co=1, rsp_id=0, rsp_valid 2 cycles after accept.
- 64-bit port 1: a=0x0000_0000_FFFF_FFFF, b=1 -> rsp_s=0x0000_0001_0000_0000, rsp_co=0, valid 3 cycles after accept.
- Contention RR=1: both ports valid continuously for 4 ops -> grants 1,0,1,0 (after reset-time op on port 0 first: 0,1,0,1); RR=0 -> all to port 0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_s stable, r0_ready/r1_ready stay 0; release -> IDLE next cycle.
- ADDARB_SUB_EN: 64-bit sub a=0, b=1 -> rsp_s=0xFFFF_FFFF_FFFF_FFFF, rsp_co=0; a=5,b=3 32-bit -> rsp_s=2, rsp_co=1.
